mem_stage_lsu: RTL

- MEM stage load/store unit of the RV32I 5-stage pipeline. It sits between the EX/MEM pipeline register and MEM/WB.
- It decodes the load/store in the MEM slot and drives a req/gnt/rvalid data-memory bus.
- It produces the aligned store byte-lanes and data, plus sign/zero-extended load data.
- It stalls the upstream pipeline while an access is outstanding and flags bus timeouts.

---
 rtl/rv32_mem_pkg.sv | 61 ++++++
 rtl/mem_stage_lsu_load_extend.sv | 33 +++
 rtl/mem_stage_lsu.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/rv32_mem_pkg.sv
// Shared MEM-stage definitions: opcodes, funct3 encodings, LSU FSM states
// and the store lane/data formatter.
package rv32_mem_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } ld_funct3_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } st_funct3_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } lsu_state_t;

  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] wdata;
  } st_lanes_t;

  // Byte enables and lane-replicated write data; loads read the full word.
  // Halfword ignores a[0], word ignores a[1:0].
  function automatic st_lanes_t store_lanes(input logic        is_store,
                                            input logic [2:0]  f3,
                                            input logic [1:0]  a,
                                            input logic [31:0] rs2);
    st_lanes_t l;
    l.be    = 4'b1111;
    l.wdata = '0;
    if (is_store) begin
      case (f3)
        SB: begin
          l.be    = 4'b0001 << a;
          l.wdata = {4{rs2[7:0]}};
        end
        SH: begin
          l.be    = 4'b0011 << {a[1], 1'b0};
          l.wdata = {2{rs2[15:0]}};
        end
        default: begin
          l.be    = 4'b1111;
          l.wdata = rs2;
        end
      endcase
    end
    return l;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_load_extend.sv
// Load data extract: picks the byte/halfword lane from the read word and
// sign- or zero-extends it according to funct3.
module load_extend
  import rv32_mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select, then extension by access type.
  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      LB:      data_o = {{24{byte_sel[7]}}, byte_sel};
      LH:      data_o = {{16{half_sel[15]}}, half_sel};
      LBU:     data_o = {24'd0, byte_sel};
      LHU:     data_o = {16'd0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: decodes the MEM-slot instruction, runs the
// req/gnt/rvalid data bus handshake, stalls upstream while an access is
// outstanding and aborts with bus_err_o after TIMEOUT_CYC cycles.
// Optional macro MISALIGN_TRAP_EN: trap misaligned halfword/word accesses.
module mem_stage_lsu
  import rv32_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned CNT_W       = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_mem_i,
  input  logic [31:0] alu_mem_i,
  input  logic [31:0] rs2_mem_i,
  input  logic        memrw_mem_i,
  input  logic        regwen_mem_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_o,
  output logic [31:0] load_data_o,
  output logic        regwen_o,
  output logic        bus_err_o,
  output logic        misalign_o
);

  lsu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      load_data_q;
  logic             regwen_q;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic        is_load, is_store, mem_op, mis_trap, active;
  logic        req, done, timeout, cnt_hit;
  logic [31:0] ld_ext;
  st_lanes_t   lanes;
  logic        unused_inst;

  assign opcode      = inst_mem_i[6:0];
  assign f3          = inst_mem_i[14:12];
  assign unused_inst = ^{inst_mem_i[31:15], inst_mem_i[11:7]};

  assign is_load  = (opcode == OP_LOAD) && (f3 inside {LB, LH, LW, LBU, LHU});
  assign is_store = (opcode == OP_STORE) && memrw_mem_i && (f3 inside {SB, SH, SW});
  assign mem_op   = is_load | is_store;

`ifdef MISALIGN_TRAP_EN
  logic misalign_q;

  // Halfword needs a[0]=0, word needs a[1:0]=0; loads and stores share codes.
  assign mis_trap = mem_op &&
                    (((f3[1:0] == 2'b01) && alu_mem_i[0]) ||
                     ((f3[1:0] == 2'b10) && (alu_mem_i[1:0] != 2'b00)));

  // One-cycle registered trap flag, aligned with the suppressed regwen_o.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= mis_trap;
  end

  assign misalign_o = misalign_q;
`else
  assign mis_trap   = 1'b0;
  assign misalign_o = 1'b0;
`endif

  // Reset gates the combinational bus/stall outputs so they drop immediately.
  assign active  = !rst && mem_op && !mis_trap;
  assign cnt_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Next-state, wait counter and handshake decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req     = 1'b0;
    done    = 1'b0;
    timeout = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (active) begin
          req     = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        req   = 1'b1;
        if (dmem_gnt_i && dmem_rvalid_i) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_hit) begin
          timeout = 1'b1;
          req     = 1'b0;
          state_d = S_IDLE;
        end else if (dmem_gnt_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dmem_rvalid_i) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_hit) begin
          timeout = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign lanes = store_lanes(is_store, f3, alu_mem_i[1:0], rs2_mem_i);

  load_extend u_load_extend (
    .rdata_i   (dmem_rdata_i),
    .addr_lo_i (alu_mem_i[1:0]),
    .funct3_i  (f3),
    .data_o    (ld_ext)
  );

  assign dmem_req_o   = req;
  assign dmem_we_o    = req & is_store;
  assign dmem_addr_o  = req ? {alu_mem_i[31:2], 2'b00} : '0;
  assign dmem_be_o    = req ? lanes.be : '0;
  assign dmem_wdata_o = req ? lanes.wdata : '0;
  assign stall_o      = active & !done & !timeout;
  assign bus_err_o    = timeout;

  // FSM state, wait counter, load result and the MEM/WB write enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      load_data_q <= '0;
      regwen_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      regwen_q <= regwen_mem_i & !stall_o & !timeout & !mis_trap;
      if (timeout) begin
        load_data_q <= '0;
      end else if (done && is_load) begin
        load_data_q <= ld_ext;
      end
    end
  end

  assign load_data_o = load_data_q;
  assign regwen_o    = regwen_q;

endmodule
